adc_multi_ch_capture: RTL

- Parametrised N-channel triggered ADC capture and aggregation block.
- Takes per-channel ADC samples on a sample strobe and, after a trigger edge, captures a programmable window.
- Packs sample pairs into tagged 32-bit words, buffers them per channel, and drains them round-robin into a single first-word-fall-through stream for the SRAM FIFO.
- Replaces the fixed 4-channel gpac_adc_rx plus external arbiter chain with one generalised block.

---
 rtl/adc_capture_pkg.sv | 32 +++
 rtl/adc_capture_fifo.sv | 57 +++++
 rtl/adc_multi_ch_capture.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/adc_capture_pkg.sv
// Shared definitions for the multi-channel ADC capture block: FSM encodings,
// output word layout and the word packing helper.
package adc_capture_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    localparam int WORD_W   = 32;
    localparam int SAMPLE_W = 14;
    localparam int HDR_BIT  = 31;
    localparam int CH_LSB   = 28;
    localparam int SA_LSB   = 14;
    localparam int SB_LSB   = 0;
    localparam int CH_ID_W  = 3;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic                hdr,
        input logic [CH_ID_W-1:0]  ch,
        input logic [SAMPLE_W-1:0] sa,
        input logic [SAMPLE_W-1:0] sb
    );
        logic [WORD_W-1:0] w;
        w                       = '0;
        w[HDR_BIT]              = hdr;
        w[CH_LSB +: CH_ID_W]    = ch;
        w[SA_LSB +: SAMPLE_W]   = sa;
        w[SB_LSB +: SAMPLE_W]   = sb;
        return w;
    endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
// Pushes while full and pops while empty are ignored.
module adc_capture_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_multi_ch_capture.sv
// N-channel triggered ADC capture: pairs samples into tagged words, buffers
// them per channel and drains the buffers round-robin as one FWFT stream.
module adc_multi_ch_capture #(
    parameter int   CHANNELS  = 4,
    parameter int   ADC_BITS  = 14,
    parameter int   DEPTH     = 16,
    parameter logic HEADER_ID = 1'b1
) (
    input  logic                         BUS_CLK,
    input  logic                         BUS_RST_B,
    input  logic                         ENABLE,
    input  logic [15:0]                  SAMPLE_COUNT,
    input  logic                         CLEAR_ERR,
    input  logic                         TRIGGER,
    input  logic                         SAMPLE_EN,
    input  logic [CHANNELS*ADC_BITS-1:0] ADC_IN,
    input  logic                         OUT_READ,
    output logic                         OUT_EMPTY,
    output logic [31:0]                  OUT_DATA,
    output logic                         BUSY,
    output logic [CHANNELS-1:0]          LOST_ERROR,
    output logic [15:0]                  TRIG_CNT
);

    import adc_capture_pkg::*;

    localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]          state;
    logic                trig_q;
    logic                trig_edge;
    logic                phase_b;
    logic                continuous;
    logic [15:0]         word_cnt;
    logic                push;
    logic                popping;

    logic [GW-1:0]       grant;
    logic [GW-1:0]       grant_next;
    logic                found;
    int                  idx;

    logic [SAMPLE_W-1:0] first_smp [CHANNELS];
    logic [SAMPLE_W-1:0] samples   [CHANNELS];
    logic [WORD_W-1:0]   words     [CHANNELS];
    logic [WORD_W-1:0]   dout      [CHANNELS];
    logic [CW-1:0]       counts    [CHANNELS];
    logic [CHANNELS-1:0] empty_vec;
    logic [CHANNELS-1:0] full_vec;
    logic [CHANNELS-1:0] has_data;
    logic [CHANNELS-1:0] pop_vec;
    logic [CHANNELS-1:0] ovf;

    assign trig_edge = TRIGGER & ~trig_q;
    assign BUSY      = (state == CAPTURE);
    assign push      = (state == CAPTURE) & ENABLE & SAMPLE_EN & phase_b;

    assign OUT_EMPTY = empty_vec[grant];
    assign OUT_DATA  = OUT_EMPTY ? '0 : dout[grant];
    assign popping   = OUT_READ & ~OUT_EMPTY;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SAMPLE_W-1:0] sample;

        always_comb begin
            sample               = '0;
            sample[ADC_BITS-1:0] = ADC_IN[i*ADC_BITS +: ADC_BITS];
        end

        assign samples[i]  = sample;
        assign words[i]    = pack_word(HEADER_ID, CH_ID_W'(i), first_smp[i], sample);
        assign pop_vec[i]  = popping & (int'(grant) == i);
        assign has_data[i] = (counts[i] != '0);
        // The registered full flag decides the drop, even if this buffer pops now.
        assign ovf[i]      = push & full_vec[i];

        adc_capture_fifo #(
            .WIDTH (WORD_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (BUS_CLK),
            .rst_b (BUS_RST_B),
            .push  (push),
            .pop   (pop_vec[i]),
            .din   (words[i]),
            .dout  (dout[i]),
            .empty (empty_vec[i]),
            .full  (full_vec[i]),
            .count (counts[i])
        );
    end

    // Round-robin: after a pop, or when parked on an empty buffer, hop to the
    // next channel holding data; stay put if there is none.
    always_comb begin
        grant_next = grant;
        found      = 1'b0;
        idx        = 0;
        if (popping || !has_data[grant]) begin
            for (int j = 1; j < CHANNELS; j++) begin
                idx = (int'(grant) + j) % CHANNELS;
                if (!found && has_data[idx[GW-1:0]]) begin
                    grant_next = idx[GW-1:0];
                    found      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_B) begin
            for (int i = 0; i < CHANNELS; i++)
                first_smp[i] <= '0;
        end else if (state == CAPTURE && ENABLE && SAMPLE_EN && !phase_b) begin
            for (int i = 0; i < CHANNELS; i++)
                first_smp[i] <= samples[i];
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_B) begin
            grant      <= '0;
            LOST_ERROR <= '0;
        end else begin
            grant      <= grant_next;
            LOST_ERROR <= (CLEAR_ERR ? '0 : LOST_ERROR) | ovf;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_B) begin
            state      <= IDLE;
            trig_q     <= 1'b0;
            phase_b    <= 1'b0;
            continuous <= 1'b0;
            word_cnt   <= '0;
            TRIG_CNT   <= '0;
        end else begin
            trig_q <= TRIGGER;
            case (state)
                IDLE: begin
                    phase_b <= 1'b0;
                    if (ENABLE)
                        state <= ARMED;
                end
                ARMED: begin
                    if (!ENABLE) begin
                        state <= IDLE;
                    end else if (trig_edge) begin
                        state      <= CAPTURE;
                        TRIG_CNT   <= TRIG_CNT + 16'd1;
                        word_cnt   <= SAMPLE_COUNT;
                        continuous <= (SAMPLE_COUNT == 16'd0);
                        phase_b    <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (!ENABLE) begin
                        // A pending phase-A sample is simply abandoned here.
                        state   <= IDLE;
                        phase_b <= 1'b0;
                    end else if (SAMPLE_EN) begin
                        phase_b <= ~phase_b;
                        if (phase_b && !continuous) begin
                            word_cnt <= word_cnt - 16'd1;
                            if (word_cnt == 16'd1)
                                state <= ARMED;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
